ifft4_stream: RTL and testbench



---
 rtl/ifft4_stream_pkg.sv | 33 +++
 rtl/ifft4_stream_if.sv | 33 +++
 rtl/ifft4_stream_bf.sv | 60 ++++++
 rtl/ifft4_stream.sv | 121 ++++++++++++
 tb/tb_ifft4_stream.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifft4_stream_pkg.sv
// ============================================================================
// Package     : fft_pkg
// Description : Shared types and constants for the radix-2 forward/inverse
//               4-point FFT datapaths (sample packing, engine FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

   // Default packed complex sample width and per-component width
   localparam int FFT_WIDTH = 32;
   localparam int FFT_HALF  = FFT_WIDTH / 2;

   // Packed complex sample: real in the upper half, imag in the lower half
   typedef struct packed {
      logic signed [FFT_HALF-1:0] re;
      logic signed [FFT_HALF-1:0] im;
   } cplx_t;

   localparam cplx_t CPLX_ZERO = '{re: '0, im: '0};

   // Frame engine states
   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      S1     = 2'd1,
      S2     = 2'd2,
      UNLOAD = 2'd3
   } ifft_state_t;

endpackage : fft_pkg

`default_nettype wire

// File: rtl/ifft4_stream_if.sv
// ============================================================================
// Interface   : ifft4_stream_if
// Description : Input/output valid-ready streams plus busy status of the
//               4-point IFFT engine. 'slave' is the engine side, 'master'
//               is the producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifft4_stream_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );
endinterface : ifft4_stream_if

`default_nettype wire

// File: rtl/ifft4_stream_bf.sv
// ============================================================================
// Module      : ifft_dif_bf
// Description : Combinational radix-2 DIF butterfly for the inverse FFT.
//               sum = (A+B), diff = (A-B) optionally rotated by +j.
//               Each component is formed at HALF+1 bits, then scaled and
//               truncated to HALF bits.
//               Build macro IFFT_SCALE_EN: defined -> each result is
//               arithmetic-shifted right by one (floor); undefined -> no
//               shift, two's-complement wrap on truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifft_dif_bf
   import fft_pkg::*;
#(
   parameter int HALF = FFT_HALF
) (
   input  logic [2*HALF-1:0] a_i,
   input  logic [2*HALF-1:0] b_i,
   input  logic              rot_j_i,
   output logic [2*HALF-1:0] sum_o,
   output logic [2*HALF-1:0] diff_o
);

`ifdef IFFT_SCALE_EN
   localparam int SHIFT = 1;
`else
   localparam int SHIFT = 0;
`endif

   logic signed [HALF-1:0] a_re, a_im, b_re, b_im;
   logic signed [HALF:0]   s_re_ext, s_im_ext, d_re_ext, d_im_ext;
   logic signed [HALF-1:0] s_re, s_im, d_re, d_im;

   assign a_re = a_i[2*HALF-1:HALF];
   assign a_im = a_i[HALF-1:0];
   assign b_re = b_i[2*HALF-1:HALF];
   assign b_im = b_i[HALF-1:0];

   // Full-precision sums: signed operands are sign-extended to HALF+1 bits
   assign s_re_ext = a_re + b_re;
   assign s_im_ext = a_im + b_im;
   assign d_re_ext = a_re - b_re;
   assign d_im_ext = a_im - b_im;

   // Floor scaling (or none) followed by truncation back to HALF bits
   assign s_re = HALF'(s_re_ext >>> SHIFT);
   assign s_im = HALF'(s_im_ext >>> SHIFT);
   assign d_re = HALF'(d_re_ext >>> SHIFT);
   assign d_im = HALF'(d_im_ext >>> SHIFT);

   assign sum_o = {s_re, s_im};

   // Multiply by +j: (r,i) -> (-i, r); negating the most negative value wraps
   assign diff_o = rot_j_i ? {-d_im, d_re} : {d_re, d_im};

endmodule : ifft_dif_bf

`default_nettype wire

// File: rtl/ifft4_stream.sv
// ============================================================================
// Module      : ifft4_stream
// Description : Streaming 4-point inverse FFT. Loads X[0..3], runs two
//               registered radix-2 DIF stages, then unloads x[0..3] in
//               natural order over valid/ready streams.
//               Build macro IFFT_SCALE_EN selects 1/4-normalised output
//               (defined) or unnormalised 4*x[n] with wrap (undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifft4_stream
   import fft_pkg::*;
#(
   parameter int WIDTH = FFT_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   ifft4_stream_if.slave  st
);

   localparam int HALF = WIDTH / 2;

   ifft_state_t      state_q, state_d;
   logic [1:0]       in_cnt_q, in_cnt_d;
   logic [1:0]       out_cnt_q, out_cnt_d;
   logic [WIDTH-1:0] in_buf_q  [4];
   logic [WIDTH-1:0] stg_q     [4];   // a0, a1, b0, b1
   logic [WIDTH-1:0] out_buf_q [4];   // x0..x3 in natural order

   logic             in_fire, out_fire;
   logic [WIDTH-1:0] a0, a1, b0, b1;
   logic [WIDTH-1:0] x0, x1, x2, x3;

   assign in_fire  = st.in_valid  && (state_q == LOAD);
   assign out_fire = st.out_ready && (state_q == UNLOAD);

   // Stage 1: even pair (X0,X2), odd pair (X1,X3) with +j on the difference
   ifft_dif_bf #(.HALF(HALF)) u_bf_s1_even (
      .a_i(in_buf_q[0]), .b_i(in_buf_q[2]), .rot_j_i(1'b0), .sum_o(a0), .diff_o(a1));
   ifft_dif_bf #(.HALF(HALF)) u_bf_s1_odd (
      .a_i(in_buf_q[1]), .b_i(in_buf_q[3]), .rot_j_i(1'b1), .sum_o(b0), .diff_o(b1));

   // Stage 2: (a0,b0) -> x0,x2 and (a1,b1) -> x1,x3
   ifft_dif_bf #(.HALF(HALF)) u_bf_s2_even (
      .a_i(stg_q[0]), .b_i(stg_q[2]), .rot_j_i(1'b0), .sum_o(x0), .diff_o(x2));
   ifft_dif_bf #(.HALF(HALF)) u_bf_s2_odd (
      .a_i(stg_q[1]), .b_i(stg_q[3]), .rot_j_i(1'b0), .sum_o(x1), .diff_o(x3));

   // State and frame counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOAD;
         in_cnt_q  <= 2'd0;
         out_cnt_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Next-state: fill four inputs, two compute cycles, drain four outputs
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               in_cnt_d = in_cnt_q + 2'd1;
               if (in_cnt_q == 2'd3) state_d = S1;
            end
         end
         S1:     state_d = S2;
         S2:     state_d = UNLOAD;
         UNLOAD: begin
            if (out_fire) begin
               out_cnt_d = out_cnt_q + 2'd1;
               if (out_cnt_q == 2'd3) state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Sample buffers: capture inputs, stage-1 results, then the output frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            in_buf_q[i]  <= '0;
            stg_q[i]     <= '0;
            out_buf_q[i] <= '0;
         end
      end else begin
         if (in_fire) in_buf_q[in_cnt_q] <= st.in_data;
         if (state_q == S1) begin
            stg_q[0] <= a0;
            stg_q[1] <= a1;
            stg_q[2] <= b0;
            stg_q[3] <= b1;
         end
         if (state_q == S2) begin
            out_buf_q[0] <= x0;
            out_buf_q[1] <= x1;
            out_buf_q[2] <= x2;
            out_buf_q[3] <= x3;
         end
      end
   end

   // Outputs decode registered state only, so they hold under backpressure
   assign st.in_ready  = (state_q == LOAD);
   assign st.out_valid = (state_q == UNLOAD);
   assign st.out_last  = (state_q == UNLOAD) && (out_cnt_q == 2'd3);
   assign st.busy      = (state_q != LOAD);
   assign st.out_data  = (state_q == UNLOAD) ? out_buf_q[out_cnt_q] : '0;

endmodule : ifft4_stream

`default_nettype wire

// File: tb/tb_ifft4_stream.sv
// ============================================================================
// Module      : tb_ifft4_stream
// Description : Self-checking bench for ifft4_stream (WIDTH=32). Directed
//               frames with literal expectations plus a per-cycle comparison
//               against an integer IDFT model. Honours IFFT_SCALE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifft4_stream;

`ifdef IFFT_SCALE_EN
   localparam int SH = 1;
`else
   localparam int SH = 0;
`endif

   logic clk;
   logic rst_n;

   ifft4_stream_if #(.WIDTH(32)) bus ();

   ifft4_stream #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .st    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Model / scoreboard state
   logic [31:0] fr [4];
   int          fcnt = 0;
   logic [31:0] exp_q [$];
   logic [31:0] cap [$];
   logic        cap_last [$];
   int          oidx = 0;
   int          n_out = 0;
   bit          hold_pend = 0;
   logic [31:0] hold_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      chk_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Truncate to a signed 16-bit component
   function automatic int tr(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   function automatic int sc(input int v);
      return tr(v >>> SH);
   endfunction

   function automatic logic [31:0] pk(input int re, input int im);
      return {re[15:0], im[15:0]};
   endfunction

   // Two-stage DIF IDFT on plain integers
   function automatic void model(input logic [31:0] x [4], output logic [31:0] y [4]);
      int r [4];
      int i [4];
      int a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i, dr, di;
      for (int k = 0; k < 4; k++) begin
         r[k] = int'($signed(x[k][31:16]));
         i[k] = int'($signed(x[k][15:0]));
      end
      a0r = sc(r[0] + r[2]);  a0i = sc(i[0] + i[2]);
      a1r = sc(r[0] - r[2]);  a1i = sc(i[0] - i[2]);
      b0r = sc(r[1] + r[3]);  b0i = sc(i[1] + i[3]);
      dr  = sc(r[1] - r[3]);  di  = sc(i[1] - i[3]);
      b1r = tr(-di);          b1i = dr;
      y[0] = pk(sc(a0r + b0r), sc(a0i + b0i));
      y[1] = pk(sc(a1r + b1r), sc(a1i + b1i));
      y[2] = pk(sc(a0r - b0r), sc(a0i - b0i));
      y[3] = pk(sc(a1r - b1r), sc(a1i - b1i));
   endfunction

   // Per-cycle monitor: record inputs, compare every output handshake, hold rule
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_pend) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_data", bus.out_data, hold_data);
         end
         hold_pend = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
         if (bus.in_valid && bus.in_ready) begin
            fr[fcnt] = bus.in_data;
            fcnt++;
            if (fcnt == 4) begin
               logic [31:0] y [4];
               model(fr, y);
               for (int k = 0; k < 4; k++) exp_q.push_back(y[k]);
               fcnt = 0;
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", bus.out_data, 32'hxxxxxxxx);
            end else begin
               check("model_data", bus.out_data, exp_q.pop_front());
            end
            check("model_last", {31'd0, bus.out_last}, {31'd0, (oidx == 3)});
            cap.push_back(bus.out_data);
            cap_last.push_back(bus.out_last);
            oidx = (oidx + 1) % 4;
            n_out++;
         end
      end
   end

   task automatic send_frame(input logic [31:0] x [4]);
      bit ok;
      int budget;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = x[k];
         budget = 0;
         do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            budget++;
         end while (!ok && budget < 100);
         if (!ok) check("in_timeout", 32'd0, 32'd1);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int target);
      int budget = 0;
      while (n_out < target && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (n_out < target) check("out_timeout", n_out, target);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] x [4],
                            input logic [31:0] lit [4], input bit chk_lat);
      int base;
      int lat;
      base = n_out;
      send_frame(x);
      if (chk_lat) begin
         lat = 0;
         while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check({tag, "_latency"}, lat, 32'd2);
      end
      wait_out(base + 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_x%0d", tag, i), cap[base+i], lit[i]);
      if (chk_lat)
         for (int i = 0; i < 4; i++)
            check($sformatf("%s_last%0d", tag, i), {31'd0, cap_last[base+i]}, {31'd0, (i == 3)});
   endtask

   logic [31:0] x_imp [4], x_bin [4], x_dc [4], x_flr [4], x_mix [4];
   logic [31:0] l_imp [4], l_bin [4], l_dc [4], l_flr [4];

   initial begin
      int base;
      x_imp = '{32'h40000000, 32'h0, 32'h0, 32'h0};
      x_bin = '{32'h0, 32'h40000000, 32'h0, 32'h0};
      x_dc  = '{32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF};
      x_flr = '{32'hFFFF0000, 32'h0, 32'h0, 32'h0};
      x_mix = '{32'h12345678, 32'h00008000, 32'hFFFE0003, 32'h80017FFF};
`ifdef IFFT_SCALE_EN
      l_imp = '{32'h10000000, 32'h10000000, 32'h10000000, 32'h10000000};
      l_bin = '{32'h10000000, 32'h00001000, 32'hF0000000, 32'h0000F000};
      l_dc  = '{32'h7FFF7FFF, 32'h0, 32'h0, 32'h0};
`else
      l_imp = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
      l_bin = '{32'h40000000, 32'h00004000, 32'hC0000000, 32'h0000C000};
      l_dc  = '{32'hFFFCFFFC, 32'h0, 32'h0, 32'h0};
`endif
      l_flr = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_frame("impulse", x_imp, l_imp, 1'b1);
      run_frame("bin1", x_bin, l_bin, 1'b0);
      run_frame("dc", x_dc, l_dc, 1'b0);
      run_frame("floor", x_flr, l_flr, 1'b0);
      base = n_out;
      send_frame(x_mix);
      wait_out(base + 4);

      // Backpressure on sample 1; in_valid asserted meanwhile must be ignored
      bus.out_ready = 1'b0;
      base = n_out;
      send_frame(x_bin);
      for (int b = 0; b < 10 && !bus.out_valid; b++) begin
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEADBEEF;
      for (int c = 0; c < 3; c++) begin
         check("bp_data", bus.out_data, l_bin[1]);
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_out(base + 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("bp_x%0d", i), cap[base+i], l_bin[i]);
      check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Reset after two outputs of a frame
      base = n_out;
      send_frame(x_bin);
      wait_out(base + 2);
      #1 rst_n = 1'b0;
      exp_q.delete();
      fcnt = 0;
      oidx = 0;
      hold_pend = 0;
      #1;
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("mid_rst_out_data", bus.out_data, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      run_frame("post_rst", x_imp, l_imp, 1'b1);

      repeat (3) @(posedge clk);
      check("leftover_expected", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_ifft4_stream

`default_nettype wire
